// File: rtl/ym2149_bus_arbiter.sv
// YM2149 bus arbiter: shares the BDIR/BC/DI bus between the CPU register path
// (request/acknowledge, read or write) and a loader engine (valid/ready, write only).
// Each transaction runs ADDR, GAP and DATA phases. Each phase is held for HOLD_CE
// pulses of the PSG clock enable.
// Optional build macro YM_ARB_ADDR_CACHE_EN keeps the last latched address. A
// transaction to that same address then skips the ADDR and GAP phases.
// The YM2149 DO pin is named ym_do because "do" is a reserved word.
module ym2149_bus_arbiter #(
   parameter int unsigned HOLD_CE = 1,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   output logic              bdir,
   output logic              bc,
   output logic [7:0]        di,
   input  logic [7:0]        ym_do,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StAddr, StGap, StData} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              pri_ld_q, pri_ld_d;     // 1: loader wins the next tie
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              wr_q, wr_d;
   logic              from_cpu_q, from_cpu_d;
   logic              bdir_q, bdir_d;
   logic              bc_q, bc_d;
   logic [7:0]        di_q, di_d;
   logic              ack_q, ack_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              busy_q;

   logic              cpu_wins, ld_wins, phase_done, cache_hit;
   logic [ADDR_W-1:0] grant_addr;

   // Arbitration and phase-exit decode
   always_comb begin
      cpu_wins   = cpu_req & (~ld_valid | ~pri_ld_q);
      ld_wins    = ld_valid & ~cpu_wins;
      grant_addr = cpu_wins ? cpu_addr : ld_addr;
      phase_done = ce & (cnt_q == 4'(HOLD_CE - 1));
   end

   // A held reset must not let the loader see a handshake that is then discarded
   assign ld_ready = ~reset & (state_q == StIdle) & ~cpu_wins;

`ifdef YM_ARB_ADDR_CACHE_EN
   logic [ADDR_W-1:0] cache_addr_q;
   logic              cache_vld_q;

   // Remember the address the chip last latched, refreshed on every ADDR exit
   always_ff @(posedge clk) begin
      if (reset) begin
         cache_addr_q <= '0;
         cache_vld_q  <= 1'b0;
      end else if ((state_q == StAddr) && phase_done) begin
         cache_addr_q <= addr_q;
         cache_vld_q  <= 1'b1;
      end
   end

   assign cache_hit = cache_vld_q & (cache_addr_q == grant_addr);
`else
   assign cache_hit = 1'b0;
`endif

   // Next-state, transaction capture and completion
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_d       = wr_q;
      from_cpu_d = from_cpu_q;
      pri_ld_d   = pri_ld_q;
      ack_d      = 1'b0;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (cpu_wins | ld_wins) begin
               addr_d     = grant_addr;
               data_d     = cpu_wins ? cpu_wdata : ld_data;
               wr_d       = cpu_wins ? cpu_wr : 1'b1;
               from_cpu_d = cpu_wins;
               pri_ld_d   = cpu_wins;
               state_d    = cache_hit ? StData : StAddr;
            end
         end
         StAddr: if (phase_done) state_d = StGap;
         StGap:  if (phase_done) state_d = StData;
         StData: begin
            if (phase_done) begin
               state_d = StIdle;
               ack_d   = from_cpu_q;
               if (from_cpu_q & ~wr_q) rdata_d = ym_do;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (ce & (state_q != StIdle)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Bus drive decoded from the next state so the pins change together with the state
   always_comb begin
      bdir_d = 1'b0;
      bc_d   = 1'b0;
      di_d   = '0;
      unique case (state_d)
         StIdle: di_d = '0;
         StAddr: begin
            bdir_d               = 1'b1;
            bc_d                 = 1'b1;
            di_d[ADDR_W-1:0]     = addr_d;
         end
         StGap:  di_d[ADDR_W-1:0] = addr_d;
         StData: begin
            if (wr_d) begin
               bdir_d = 1'b1;
               di_d   = data_d;
            end else begin
               bc_d = 1'b1;
            end
         end
         default: di_d = '0;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         pri_ld_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_q       <= 1'b0;
         from_cpu_q <= 1'b0;
         bdir_q     <= 1'b0;
         bc_q       <= 1'b0;
         di_q       <= '0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pri_ld_q   <= pri_ld_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_q       <= wr_d;
         from_cpu_q <= from_cpu_d;
         bdir_q     <= bdir_d;
         bc_q       <= bc_d;
         di_q       <= di_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         busy_q     <= (state_d != StIdle);
      end
   end

   assign cpu_ack   = ack_q;
   assign cpu_rdata = rdata_q;
   assign bdir      = bdir_q;
   assign bc        = bc_q;
   assign di        = di_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ym2149_bus_arbiter.sv
// Bench for ym2149_bus_arbiter: per-cycle vector table, hand sequences for reset,
// slow CE and the address cache, and a random run against a transaction-level model.
module tb_ym2149_bus_arbiter;

`ifdef YM_ARB_ADDR_CACHE_EN
   localparam bit CacheEn = 1'b1;
`else
   localparam bit CacheEn = 1'b0;
`endif

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, ce1, ce2, cpu_req, cpu_wr, ld_valid, ym_clr;
   logic [3:0] cpu_addr, ld_addr;
   logic [7:0] cpu_wdata, ld_data;

   logic       ack1, ld_ready1, bdir1, bc1, busy1;
   logic [7:0] rdata1, di1, do1;
   logic       ack2, ld_ready2, bdir2, bc2, busy2;
   logic [7:0] rdata2, di2, do2;

   assign do2 = 8'h00;

   ym2149_bus_arbiter #(.HOLD_CE(1), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .ce(ce1),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(ack1), .cpu_rdata(rdata1),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready1),
      .bdir(bdir1), .bc(bc1), .di(di1), .ym_do(do1), .busy(busy1));

   ym2149_bus_arbiter #(.HOLD_CE(2), .ADDR_W(4)) dut2 (
      .clk(clk), .reset(reset), .ce(ce2),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(ack2), .cpu_rdata(rdata2),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready2),
      .bdir(bdir2), .bc(bc2), .di(di2), .ym_do(do2), .busy(busy2));

   // Behavioural YM2149 register file on the first DUT's bus
   logic [7:0] ym_regs [16];
   logic [3:0] ym_latch;
   always @(posedge clk) begin
      if (ym_clr) begin
         for (int i = 0; i < 16; i++) ym_regs[i] <= 8'h00;
         ym_latch <= 4'h0;
      end else if (bdir1 && bc1) begin
         ym_latch <= di1[3:0];
      end else if (bdir1 && !bc1) begin
         ym_regs[ym_latch] <= di1;
      end
   end
   assign do1 = (!bdir1 && bc1) ? ym_regs[ym_latch] : 8'hFF;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic       rst, creq, cwr;
      logic [3:0] caddr;
      logic [7:0] cwd;
      logic       lv;
      logic [3:0] la;
      logic [7:0] ldat;
      logic       e_ldr, e_bdir, e_bc;
      logic [7:0] e_di;
      logic       e_ack, e_busy;
      logic [7:0] e_rd;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic creq, input logic cwr,
                               input logic [3:0] caddr, input logic [7:0] cwd,
                               input logic lv, input logic [3:0] la, input logic [7:0] ldat,
                               input logic e_ldr, input logic e_bdir, input logic e_bc,
                               input logic [7:0] e_di, input logic e_ack, input logic e_busy,
                               input logic [7:0] e_rd);
      vec_t v;
      v = {rst, creq, cwr, caddr, cwd, lv, la, ldat, e_ldr, e_bdir, e_bc, e_di, e_ack, e_busy,
           e_rd};
      return v;
   endfunction

   // Transaction-level reference model state for the random run
   bit         m_idle, cpu_first, m_ack, t_cpu, t_wr, t_hit, c_vld;
   int         left;
   logic [3:0] t_a, c_a;
   logic [7:0] t_d, m_rdata;
   logic [7:0] exp_regs [16];

   task automatic rstep(input bit stim);
      bit cw, ldr_seen;
      @(negedge clk);
      cw = cpu_req && (cpu_first || !ld_valid);
      chk("rnd_ld_ready", ld_ready1, m_idle && !cw);
      ldr_seen = ld_ready1;
      m_ack = 1'b0;
      if (m_idle) begin
         if (cw || ld_valid) begin
            t_cpu     = cw;
            t_wr      = cw ? cpu_wr : 1'b1;
            t_a       = cw ? cpu_addr : ld_addr;
            t_d       = cw ? cpu_wdata : ld_data;
            cpu_first = !cw;
            t_hit     = CacheEn && c_vld && (c_a == t_a);
            left      = t_hit ? 1 : 3;
            m_idle    = 1'b0;
         end
      end else if (ce1) begin
         left--;
         if (left == 0) begin
            m_idle = 1'b1;
            if (!t_hit) begin
               c_vld = 1'b1;
               c_a   = t_a;
            end
            if (t_wr) exp_regs[t_a] = t_d;
            if (t_cpu) begin
               m_ack = 1'b1;
               if (!t_wr) m_rdata = exp_regs[t_a];
            end
         end
      end
      tick();
      chk("rnd_busy", busy1, !m_idle);
      chk("rnd_ack", ack1, m_ack);
      chk("rnd_rdata", rdata1, m_rdata);
      if (cpu_req && ack1) begin
         if (stim && ($urandom_range(2) == 0)) begin
            cpu_wr    = 1'($urandom);
            cpu_addr  = 4'($urandom);
            cpu_wdata = 8'($urandom);
         end else begin
            cpu_req = 1'b0;
         end
      end else if (stim && !cpu_req && ($urandom_range(3) == 0)) begin
         cpu_req   = 1'b1;
         cpu_wr    = 1'($urandom);
         cpu_addr  = 4'($urandom);
         cpu_wdata = 8'($urandom);
      end
      if (ld_valid && ldr_seen) ld_valid = 1'b0;
      if (stim && !ld_valid && ($urandom_range(3) == 0)) begin
         ld_valid = 1'b1;
         ld_addr  = 4'($urandom);
         ld_data  = 8'($urandom);
      end
      ce1 = stim ? ($urandom_range(3) != 0) : 1'b1;
   endtask

   vec_t tv [28];
   int   n;
   bit   ce_now, exp_ack, seen_ack;

   initial begin
      reset = 1'b1; ce1 = 1'b1; ce2 = 1'b0; ym_clr = 1'b1;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
      ld_valid = 1'b0; ld_addr = 4'h0; ld_data = 8'h00;
      tick();
      @(negedge clk);
      chk("reset_ld_ready", ld_ready1, 1'b0);
      tick();
      chk("reset_bdir", bdir1, 1'b0);
      chk("reset_bc", bc1, 1'b0);
      chk("reset_di", di1, 8'h00);
      chk("reset_ack", ack1, 1'b0);
      chk("reset_rdata", rdata1, 8'h00);
      chk("reset_busy", busy1, 1'b0);
      chk("reset_busy2", busy2, 1'b0);
      reset = 1'b0; ym_clr = 1'b0;
      @(negedge clk);
      chk("idle_ld_ready", ld_ready1, 1'b1);
      tick();

`ifndef YM_ARB_ADDR_CACHE_EN
      // rst creq cwr caddr cwd lv la ldat | ldr bdir bc di ack busy rdata
      tv[0]  = mk(0,1,1,4'h7,8'h38,0,4'h0,8'h00, 0,1,1,8'h07,0,1,8'h00);
      tv[1]  = mk(0,1,1,4'h7,8'h38,0,4'h0,8'h00, 0,0,0,8'h07,0,1,8'h00);
      tv[2]  = mk(0,1,1,4'h7,8'h38,0,4'h0,8'h00, 0,1,0,8'h38,0,1,8'h00);
      tv[3]  = mk(0,1,1,4'h7,8'h38,0,4'h0,8'h00, 0,0,0,8'h00,1,0,8'h00);
      tv[4]  = mk(0,0,0,4'h0,8'h00,0,4'h0,8'h00, 1,0,0,8'h00,0,0,8'h00);
      tv[5]  = mk(0,0,0,4'h0,8'h00,1,4'h0,8'h5A, 1,1,1,8'h00,0,1,8'h00);
      tv[6]  = mk(0,0,0,4'h0,8'h00,0,4'h0,8'h00, 0,0,0,8'h00,0,1,8'h00);
      tv[7]  = mk(0,0,0,4'h0,8'h00,0,4'h0,8'h00, 0,1,0,8'h5A,0,1,8'h00);
      tv[8]  = mk(0,0,0,4'h0,8'h00,0,4'h0,8'h00, 0,0,0,8'h00,0,0,8'h00);
      tv[9]  = mk(0,1,0,4'h0,8'h00,0,4'h0,8'h00, 0,1,1,8'h00,0,1,8'h00);
      tv[10] = mk(0,1,0,4'h0,8'h00,0,4'h0,8'h00, 0,0,0,8'h00,0,1,8'h00);
      tv[11] = mk(0,1,0,4'h0,8'h00,0,4'h0,8'h00, 0,0,1,8'h00,0,1,8'h00);
      tv[12] = mk(0,1,0,4'h0,8'h00,0,4'h0,8'h00, 0,0,0,8'h00,1,0,8'h5A);
      tv[13] = mk(0,0,0,4'h0,8'h00,0,4'h0,8'h00, 1,0,0,8'h00,0,0,8'h5A);
      tv[14] = mk(1,0,0,4'h0,8'h00,0,4'h0,8'h00, 0,0,0,8'h00,0,0,8'h00);
      tv[15] = mk(0,1,1,4'h3,8'h11,1,4'h5,8'h22, 0,1,1,8'h03,0,1,8'h00);
      tv[16] = mk(0,1,1,4'h3,8'h11,1,4'h5,8'h22, 0,0,0,8'h03,0,1,8'h00);
      tv[17] = mk(0,1,1,4'h3,8'h11,1,4'h5,8'h22, 0,1,0,8'h11,0,1,8'h00);
      tv[18] = mk(0,1,1,4'h3,8'h11,1,4'h5,8'h22, 0,0,0,8'h00,1,0,8'h00);
      tv[19] = mk(0,1,1,4'h4,8'h33,1,4'h5,8'h22, 1,1,1,8'h05,0,1,8'h00);
      tv[20] = mk(0,1,1,4'h4,8'h33,0,4'h0,8'h00, 0,0,0,8'h05,0,1,8'h00);
      tv[21] = mk(0,1,1,4'h4,8'h33,0,4'h0,8'h00, 0,1,0,8'h22,0,1,8'h00);
      tv[22] = mk(0,1,1,4'h4,8'h33,0,4'h0,8'h00, 0,0,0,8'h00,0,0,8'h00);
      tv[23] = mk(0,1,1,4'h4,8'h33,0,4'h0,8'h00, 0,1,1,8'h04,0,1,8'h00);
      tv[24] = mk(0,1,1,4'h4,8'h33,0,4'h0,8'h00, 0,0,0,8'h04,0,1,8'h00);
      tv[25] = mk(0,1,1,4'h4,8'h33,0,4'h0,8'h00, 0,1,0,8'h33,0,1,8'h00);
      tv[26] = mk(0,1,1,4'h4,8'h33,0,4'h0,8'h00, 0,0,0,8'h00,1,0,8'h00);
      tv[27] = mk(0,0,0,4'h0,8'h00,0,4'h0,8'h00, 1,0,0,8'h00,0,0,8'h00);
      for (int i = 0; i < 28; i++) begin
         reset = tv[i].rst; cpu_req = tv[i].creq; cpu_wr = tv[i].cwr;
         cpu_addr = tv[i].caddr; cpu_wdata = tv[i].cwd;
         ld_valid = tv[i].lv; ld_addr = tv[i].la; ld_data = tv[i].ldat;
         @(negedge clk);
         chk($sformatf("vec%0d_ld_ready", i), ld_ready1, tv[i].e_ldr);
         tick();
         chk($sformatf("vec%0d_bdir", i), bdir1, tv[i].e_bdir);
         chk($sformatf("vec%0d_bc", i), bc1, tv[i].e_bc);
         chk($sformatf("vec%0d_di", i), di1, tv[i].e_di);
         chk($sformatf("vec%0d_ack", i), ack1, tv[i].e_ack);
         chk($sformatf("vec%0d_busy", i), busy1, tv[i].e_busy);
         chk($sformatf("vec%0d_rdata", i), rdata1, tv[i].e_rd);
      end
      reset = 1'b0;
      chk("ym_reg7", ym_regs[7], 8'h38);
      chk("ym_reg0", ym_regs[0], 8'h5A);
      chk("ym_reg3", ym_regs[3], 8'h11);
      chk("ym_reg4", ym_regs[4], 8'h33);
      chk("ym_reg5", ym_regs[5], 8'h22);
`else
      // Two loader writes to reg 8: the second skips ADDR and GAP
      reset = 1'b1; tick(); reset = 1'b0;
      ld_valid = 1'b1; ld_addr = 4'h8; ld_data = 8'h0F;
      tick();
      chk("c1_addr_bdir", bdir1, 1'b1); chk("c1_addr_bc", bc1, 1'b1);
      chk("c1_addr_di", di1, 8'h08);
      ld_valid = 1'b0;
      tick();
      chk("c1_gap_bdir", bdir1, 1'b0); chk("c1_gap_di", di1, 8'h08);
      tick();
      chk("c1_data_bdir", bdir1, 1'b1); chk("c1_data_di", di1, 8'h0F);
      tick();
      chk("c1_busy", busy1, 1'b0);
      ld_valid = 1'b1; ld_data = 8'h0A;
      tick();
      chk("c2_bdir", bdir1, 1'b1); chk("c2_bc", bc1, 1'b0); chk("c2_di", di1, 8'h0A);
      ld_valid = 1'b0;
      tick();
      chk("c2_busy", busy1, 1'b0);
      chk("c2_ym_reg8", ym_regs[8], 8'h0A);
`endif

      // Reset during the DATA phase of a write, then a clean request
      reset = 1'b1; tick(); reset = 1'b0;
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 4'h2; cpu_wdata = 8'h44; ld_valid = 1'b0;
      tick(); tick(); tick();
      chk("mid_data_bdir", bdir1, 1'b1);
      chk("mid_data_di", di1, 8'h44);
      reset = 1'b1;
      tick();
      chk("mid_rst_bdir", bdir1, 1'b0);
      chk("mid_rst_bc", bc1, 1'b0);
      chk("mid_rst_di", di1, 8'h00);
      chk("mid_rst_ack", ack1, 1'b0);
      chk("mid_rst_busy", busy1, 1'b0);
      reset = 1'b0; cpu_wdata = 8'h55;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("after_rst_ack%0d", k), ack1, (k == 4) ? 1'b1 : 1'b0);
      end
      cpu_req = 1'b0;
      tick();
      chk("after_rst_ym_reg2", ym_regs[2], 8'h55);
      chk("after_rst_ack_gone", ack1, 1'b0);

      // HOLD_CE=2 instance with CE pulsing once every 8 clocks
      ce1 = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 4'h1; cpu_wdata = 8'h99;
      n = 0; seen_ack = 1'b0;
      for (int cyc = 0; cyc < 64 && !(seen_ack && n == 6 && cyc > 56); cyc++) begin
         ce2 = ((cyc % 8) == 7);
         ce_now = ce2;
         tick();
         exp_ack = 1'b0;
         if (cyc > 0 && ce_now) begin
            n++;
            exp_ack = (n == 6);
         end
         if (n < 2) begin
            chk($sformatf("ce%0d_bdir", cyc), bdir2, 1'b1);
            chk($sformatf("ce%0d_bc", cyc), bc2, 1'b1);
            chk($sformatf("ce%0d_di", cyc), di2, 8'h01);
         end else if (n < 4) begin
            chk($sformatf("ce%0d_bdir", cyc), bdir2, 1'b0);
            chk($sformatf("ce%0d_bc", cyc), bc2, 1'b0);
            chk($sformatf("ce%0d_di", cyc), di2, 8'h01);
         end else if (n < 6) begin
            chk($sformatf("ce%0d_bdir", cyc), bdir2, 1'b1);
            chk($sformatf("ce%0d_bc", cyc), bc2, 1'b0);
            chk($sformatf("ce%0d_di", cyc), di2, 8'h99);
         end else begin
            chk($sformatf("ce%0d_bdir", cyc), bdir2, 1'b0);
            chk($sformatf("ce%0d_busy", cyc), busy2, 1'b0);
         end
         chk($sformatf("ce%0d_ack", cyc), ack2, exp_ack);
         if (exp_ack) begin
            cpu_req  = 1'b0;
            seen_ack = 1'b1;
         end
      end
      chk("ce_ack_seen", seen_ack, 1'b1);
      ce2 = 1'b0; cpu_req = 1'b0;

      // Random traffic against the transaction-level model
      reset = 1'b1; ce1 = 1'b1; ym_clr = 1'b1;
      tick();
      reset = 1'b0; ym_clr = 1'b0;
      m_idle = 1'b1; cpu_first = 1'b1; m_ack = 1'b0; m_rdata = 8'h00; c_vld = 1'b0;
      c_a = 4'h0; left = 0; t_hit = 1'b0;
      for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
      for (int i = 0; i < 1500; i++) rstep(1'b1);
      for (int i = 0; i < 40; i++) rstep(1'b0);
      for (int i = 0; i < 16; i++) chk($sformatf("rnd_ym_reg%0d", i), ym_regs[i], exp_regs[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
